mac_seq_ctrl: RTL and testbench
===============================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8: signed operand width.
REQ-002 SHALL have parameter AW, default 16: signed accumulator/result width (AW >= 2*DW).
REQ-003 SHALL have parameter LW, default 8: vector-length field width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the posedge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request a new dot product; sampled only in IDLE.
REQ-007 SHALL have port len, input, LW: number of operand pairs; captured with start.
REQ-008 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port in_valid, input, 1: operand pair a/b is valid.
REQ-010 SHALL have port in_ready, output, 1: controller accepts a pair this cycle.
REQ-011 SHALL have port a, input, DW, signed: first operand.
REQ-012 SHALL have port b, input, DW, signed: second operand.
REQ-013 SHALL have port out_valid, output, 1: f and ovf hold a finished result.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-015 SHALL have port f, output, AW, signed: accumulated sum of products.
REQ-016 SHALL have port ovf, output, 1: sticky signed-overflow flag for the current job.

Function
REQ-017 SHALL implement the states IDLE, LOAD, DRAIN and DONE.
REQ-018 SHALL, in IDLE with start=1 and len>0, capture len into a remaining-count register, clear f and ovf, and enter LOAD.
REQ-019 SHALL, in IDLE with start=1 and len=0, clear f and ovf and enter DONE directly.
REQ-020 SHALL ignore start in LOAD, DRAIN and DONE, with no effect on len, f or the count.
REQ-021 SHALL drive in_ready=1 only in LOAD.
REQ-022 SHALL treat an edge with in_valid=1 and in_ready=1 as a transfer; no other edge is a transfer.
REQ-023 SHALL, on each transfer, register a and b into operand registers, set an operand-pending flag, and decrement the remaining count.
REQ-024 SHALL, on each edge where operand-pending is set, update f to f + a_reg*b_reg and clear operand-pending unless a new transfer occurs on the same edge.
REQ-025 SHALL form the product full-width signed (2*DW), sign-extend it to AW, and wrap the sum modulo 2^AW.
REQ-026 SHALL set ovf on any accumulate whose true signed sum is outside the AW range; ovf stays set until the next job start or reset.
REQ-027 SHALL sustain one transfer per cycle; in_valid gaps SHALL stall the count with no accumulate of stale data.
REQ-028 SHALL move from LOAD to DRAIN on the transfer edge that brings the remaining count to 0.
REQ-029 SHALL, in DRAIN, perform the final accumulate and enter DONE on the next edge.
REQ-030 SHALL make out_valid go high in the cycle after the edge at T+1, where T is the last transfer edge.
REQ-031 SHALL drive out_valid=1 only in DONE, holding f and ovf stable while out_valid=1 and out_ready=0.
REQ-032 SHALL, in DONE with out_ready=1, return to IDLE on that edge while f and ovf keep their values until the next start.
REQ-033 SHALL leave a, b and in_valid as don't-care outside LOAD; they SHALL NOT alter any state there.

Reset
REQ-034 SHALL, on any edge with reset=1 and regardless of state, drive the state to IDLE, f=0, ovf=0, the count to 0, operand registers to 0 and operand-pending to 0.
REQ-035 SHALL, under reset, hold busy=0, in_ready=0 and out_valid=0; a mid-job reset SHALL abandon the job with no result produced.

Verification
REQ-036 SHALL cover the basic job: len=3 with pairs (2,3), (-4,5), (7,-1) back-to-back; out_valid is expected on the 2nd edge after the last transfer with f=-21 (16'hFFEB) and ovf=0.
REQ-037 SHALL cover stalls: the same job with in_valid low for 2 cycles between pairs; the expected result is the identical f=-21, with the out_valid delay counted from the last transfer only.
REQ-038 SHALL cover overflow: len=3 with three pairs (127,127); the expected result is f=-17149 (48387 wrapped) and ovf=1, with ovf=0 again after the next start.
REQ-039 SHALL cover the zero-length job: start with len=0; DONE is expected the next cycle with f=0, ovf=0 and in_ready never high.
REQ-040 SHALL cover backpressure and stray start: hold out_ready=0 for 5 cycles in DONE and pulse start; f is expected stable, start ignored, and IDLE reached on the out_ready edge.
REQ-041 SHALL cover reset mid-job: assert reset after 2 of 4 transfers; the expected state is IDLE with f=0 and no out_valid, and a following len=1 job with (-8,-8) is expected to give f=64.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// MacSeqCtrl -- sequenced signed multiply-accumulate controller
//
// Computes the dot product of a stream of signed operand pairs. A job is
// started from IDLE with a length; the controller then accepts that many
// a/b pairs over a valid/ready handshake, accumulates their products into
// f (wrapping modulo 2^AW), and presents the result with a sticky signed
// overflow flag until the consumer takes it.
//
// Parameters
//    DW : signed operand width
//    AW : signed accumulator / result width (AW >= 2*DW)
//    LW : vector-length field width
//
// Ports
//    clk       : single clock, all state changes on the rising edge
//    reset     : synchronous, active-high reset
//    start     : request a new job (only looked at in IDLE)
//    len       : number of operand pairs, captured together with start
//    busy      : high whenever the controller is not IDLE
//    in_valid  : a/b carry a valid operand pair
//    in_ready  : controller will take a pair this cycle (LOAD only)
//    a, b      : signed operands
//    out_valid : f/ovf hold a finished result (DONE only)
//    out_ready : consumer accepts the result
//    f         : accumulated sum of products
//    ovf       : sticky signed-overflow flag for the current job
// ---------------------------------------------------------------------------
module mac_seq_ctrl #(
   parameter int DW = 8,
   parameter int AW = 16,
   parameter int LW = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [LW-1:0]        len,
   output logic                 busy,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] a,
   input  logic signed [DW-1:0] b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [AW-1:0] f,
   output logic                 ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } stateT;

   stateT state;
   stateT nextState;

   logic [LW-1:0]          remCount;
   logic signed [DW-1:0]   aReg;
   logic signed [DW-1:0]   bReg;
   logic                   pending;

   logic                   jobStart;
   logic                   transfer;

   logic signed [2*DW-1:0] product;
   logic signed [AW-1:0]   prodExt;
   logic signed [AW-1:0]   sumWrap;
   logic                   sumOvf;

   // State register. Reset always wins and drops any job in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and handshake decode. The LOAD state owns the input
   // handshake and leaves for DRAIN on the transfer that consumes the last
   // remaining pair; DRAIN exists only so the final registered pair gets its
   // accumulate before the result is shown. All outputs are forced low while
   // reset is asserted so a consumer never sees a stale busy/valid during
   // the reset cycle, whatever state the register still holds.
   always_comb begin
      nextState = state;
      busy      = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      jobStart  = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               jobStart = 1'b1;
               if (len == '0) begin
                  nextState = DONE;
               end else begin
                  nextState = LOAD;
               end
            end
         end
         LOAD: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            if (in_valid && (remCount == LW'(1))) begin
               nextState = DRAIN;
            end
         end
         DRAIN: begin
            busy      = 1'b1;
            nextState = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase

      if (reset) begin
         busy      = 1'b0;
         in_ready  = 1'b0;
         out_valid = 1'b0;
         jobStart  = 1'b0;
      end
   end

   // A transfer needs both sides of the handshake; since in_ready is only
   // high in LOAD, a/b/in_valid cannot disturb anything in other states.
   assign transfer = in_valid && in_ready;

   // Product is formed at full 2*DW precision, sign-extended to the
   // accumulator width and added with natural wraparound. Overflow is the
   // classic signed test: both addends share a sign and the wrapped sum
   // does not.
   always_comb begin
      product = (2*DW)'(aReg) * (2*DW)'(bReg);
      prodExt = AW'(product);
      sumWrap = f + prodExt;
      sumOvf  = (f[AW-1] == prodExt[AW-1]) && (sumWrap[AW-1] != f[AW-1]);
   end

   // Datapath. Operands are registered on a transfer and accumulated on the
   // following edge, which lets one pair be accepted per cycle while the
   // previous one is being added. The pending flag is simply reloaded with
   // "was there a transfer this edge", so a gap in in_valid clears it and
   // the old operand registers are never accumulated twice. Starting a job
   // clears the result and the sticky flag; f and ovf otherwise hold their
   // value through DONE and back into IDLE until the next start.
   always_ff @(posedge clk) begin
      if (reset) begin
         remCount <= '0;
         aReg     <= '0;
         bReg     <= '0;
         pending  <= 1'b0;
         f        <= '0;
         ovf      <= 1'b0;
      end else if (jobStart) begin
         remCount <= len;
         pending  <= 1'b0;
         f        <= '0;
         ovf      <= 1'b0;
      end else begin
         if (pending) begin
            f <= sumWrap;
            if (sumOvf) begin
               ovf <= 1'b1;
            end
         end
         if (transfer) begin
            aReg     <= a;
            bReg     <= b;
            remCount <= remCount - LW'(1);
         end
         pending <= transfer;
      end
   end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_seq_ctrl -- directed self-checking bench for mac_seq_ctrl
//
// Drives hand-written jobs (basic, stalled, overflowing, zero length,
// backpressure with a stray start, reset in the middle of a job) and
// compares the outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_mac_seq_ctrl;

   logic                clk;
   logic                reset;
   logic                start;
   logic [7:0]          len;
   logic                busy;
   logic                in_valid;
   logic                in_ready;
   logic signed [7:0]   a;
   logic signed [7:0]   b;
   logic                out_valid;
   logic                out_ready;
   logic signed [15:0]  f;
   logic                ovf;

   int total;
   int bad;

   logic signed [7:0] pa [4];
   logic signed [7:0] pb [4];

   mac_seq_ctrl #(
      .DW(8),
      .AW(16),
      .LW(8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .len      (len),
      .busy     (busy),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .f        (f),
      .ovf      (ovf)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the bench always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("[TB] FAIL %s: got %0d required %0d", tag, obs, expv);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   // Drive one beat of the operand interface.
   task automatic applyStimulus(input logic v, input logic signed [7:0] av,
                                input logic signed [7:0] bv);
      in_valid = v;
      a        = av;
      b        = bv;
   endtask

   // Run a job of n pairs from pa/pb with `gap` idle beats between pairs,
   // then wait (bounded) for the result and check it. Leaves DUT in DONE.
   task automatic runJob(input string name, input int n, input int gap,
                         input int expF, input logic expOvf);
      int k;
      start = 1'b1;
      len   = 8'(n);
      stepClk();
      start = 1'b0;
      len   = 8'd0;
      checkOutput({name, "_busy"}, 32'(busy), 1);
      checkOutput({name, "_rdy"}, 32'(in_ready), 1);
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            for (int g = 0; g < gap; g++) begin
               applyStimulus(1'b0, 8'sd55, -8'sd33);
               stepClk();
            end
         end
         applyStimulus(1'b1, pa[i], pb[i]);
         stepClk();
      end
      applyStimulus(1'b0, 8'sd0, 8'sd0);
      checkOutput({name, "_ovT"}, 32'(out_valid), 0);
      k = 0;
      while (out_valid !== 1'b1 && k < 8) begin
         stepClk();
         k++;
      end
      checkOutput({name, "_lat"}, k, 1);
      checkOutput({name, "_f"}, f, expF);
      checkOutput({name, "_ovf"}, 32'(ovf), 32'(expOvf));
   endtask

   // Hand the result to the consumer and confirm the return to IDLE.
   task automatic releaseResult(input string name, input int expF);
      out_ready = 1'b1;
      stepClk();
      out_ready = 1'b0;
      checkOutput({name, "_relV"}, 32'(out_valid), 0);
      checkOutput({name, "_relB"}, 32'(busy), 0);
      checkOutput({name, "_relF"}, f, expF);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      reset     = 1'b1;
      start     = 1'b0;
      len       = 8'd0;
      out_ready = 1'b0;
      applyStimulus(1'b0, 8'sd0, 8'sd0);

      // Reset state.
      stepClk();
      stepClk();
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_rdy", 32'(in_ready), 0);
      checkOutput("rst_ov", 32'(out_valid), 0);
      checkOutput("rst_f", f, 0);
      checkOutput("rst_ovf", 32'(ovf), 0);
      reset = 1'b0;
      stepClk();
      checkOutput("idle_busy", 32'(busy), 0);

      // Basic job: 2*3 + (-4*5) + (7*-1) = -21.
      pa[0] = 8'sd2;  pb[0] = 8'sd3;
      pa[1] = -8'sd4; pb[1] = 8'sd5;
      pa[2] = 8'sd7;  pb[2] = -8'sd1;
      runJob("basic", 3, 0, -21, 1'b0);
      releaseResult("basic", -21);

      // Same job with two-cycle stalls between pairs.
      runJob("stall", 3, 2, -21, 1'b0);
      releaseResult("stall", -21);

      // Overflow: 3*16129 = 48387 -> wraps to -17149.
      for (int i = 0; i < 3; i++) begin
         pa[i] = 8'sd127;
         pb[i] = 8'sd127;
      end
      runJob("ovfl", 3, 0, -17149, 1'b1);
      releaseResult("ovfl", -17149);
      checkOutput("ovfl_hold", 32'(ovf), 1);

      // Zero-length job also shows ovf cleared by the new start.
      start = 1'b1;
      len   = 8'd0;
      checkOutput("zero_rdy0", 32'(in_ready), 0);
      stepClk();
      start = 1'b0;
      checkOutput("zero_ov", 32'(out_valid), 1);
      checkOutput("zero_rdy", 32'(in_ready), 0);
      checkOutput("zero_f", f, 0);
      checkOutput("zero_ovf", 32'(ovf), 0);
      releaseResult("zero", 0);

      // Backpressure with a stray start while in DONE.
      pa[0] = 8'sd2;  pb[0] = 8'sd3;
      pa[1] = -8'sd4; pb[1] = 8'sd5;
      pa[2] = 8'sd7;  pb[2] = -8'sd1;
      runJob("bp", 3, 0, -21, 1'b0);
      for (int c = 0; c < 5; c++) begin
         start = (c == 2);
         len   = 8'd5;
         stepClk();
         checkOutput("bp_ov", 32'(out_valid), 1);
         checkOutput("bp_f", f, -21);
      end
      start = 1'b0;
      len   = 8'd0;
      releaseResult("bp", -21);
      stepClk();
      checkOutput("bp_idle", 32'(busy), 0);

      // Reset in the middle of a 4-pair job.
      start = 1'b1;
      len   = 8'd4;
      stepClk();
      start = 1'b0;
      applyStimulus(1'b1, 8'sd10, 8'sd10);
      stepClk();
      applyStimulus(1'b1, 8'sd20, 8'sd20);
      stepClk();
      checkOutput("mid_f", f, 100);
      applyStimulus(1'b1, 8'sd30, 8'sd30);
      reset = 1'b1;
      #1;
      checkOutput("mid_rdy", 32'(in_ready), 0);
      checkOutput("mid_busy", 32'(busy), 0);
      stepClk();
      reset = 1'b0;
      applyStimulus(1'b0, 8'sd0, 8'sd0);
      checkOutput("mid_f0", f, 0);
      checkOutput("mid_ovf", 32'(ovf), 0);
      stepClk();
      checkOutput("mid_ov", 32'(out_valid), 0);
      checkOutput("mid_idle", 32'(busy), 0);

      // Follow-up single-pair job: (-8)*(-8) = 64.
      pa[0] = -8'sd8;
      pb[0] = -8'sd8;
      runJob("post", 1, 0, 64, 1'b0);
      releaseResult("post", 64);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
